input_debounce: RTL and testbench

Conditions the raw push-button and slide-switch inputs of the lab latch/flip-flop exercise before they reach the storage elements. Each channel is synchronised into the `clk` domain and filtered by a stable-count debouncer. The block produces a clean level per channel plus single-cycle rise and fall strobes. Its outputs drive the `s`, `r`, `d` and `ck` inputs of the latch/flip-flop comparison stage directly downstream, so that stage sees bounce-free, glitch-free stimulus.

---
 rtl/input_debounce.sv | 144 ++++++++++++++
 tb/tb_input_debounce.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/input_debounce.sv
// -----------------------------------------------------------------------------
// input_debounce
//   Conditions raw board inputs (push-buttons / slide switches) for the
//   latch/flip-flop comparison stage. Each channel is synchronised into the
//   clk domain with two flops, then filtered by a stable-count debouncer. A
//   channel's level follows its synchronised input only after the input has
//   differed from the current level for DB_CYCLES consecutive edges. Single-
//   cycle rise/fall strobes mark each accepted level change.
//
// Parameters
//   WIDTH      number of independent channels (bit0=s, bit1=r, bit2=d, bit3=ck)
//   DB_CYCLES  consecutive differing edges needed to accept a change (>= 2)
//
// Ports
//   clk    in   1      system clock, rising-edge active
//   rst_n  in   1      asynchronous active-low reset
//   raw    in   WIDTH  asynchronous, possibly bouncing inputs
//   level  out  WIDTH  debounced registered level
//   rise   out  WIDTH  one-cycle strobe on an accepted 0->1
//   fall   out  WIDTH  one-cycle strobe on an accepted 1->0
//
// All outputs come straight from flops; there is no combinational path from
// raw to any output.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// input_debounce_lane
//   One channel: two-flop synchroniser, stable-count filter and strobe flops.
//
// Ports
//   clk      in   1  system clock
//   rst_n    in   1  asynchronous active-low reset
//   raw_i    in   1  asynchronous raw input
//   level_o  out  1  debounced level
//   rise_o   out  1  accepted 0->1 strobe
//   fall_o   out  1  accepted 1->0 strobe
// -----------------------------------------------------------------------------
module input_debounce_lane #(
    parameter int DB_CYCLES = 16,
    parameter int CW        = $clog2(DB_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q,  rise_d;
    logic          fall_q,  fall_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Synchroniser: raw_i is asynchronous, so sync1_q may go metastable;
    // sync2_q is the first flop whose value the filter is allowed to use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Filter. cnt_q counts consecutive edges on which sync2_q disagreed with
    // level_q. Any agreeing edge (a bounce back) restarts from zero. The
    // counter only returns to zero from CNT_MAX together with the level
    // update, so it never wraps on its own.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Strobes are registered alongside level, so they are high in exactly the
    // cycle level first shows its new value. A further change needs at least
    // DB_CYCLES (>= 2) more edges, so strobes can never be back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

module input_debounce #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // A one-edge filter would make the strobe invariants impossible to hold.
    if (DB_CYCLES < 2) begin : g_bad_param
        $error("input_debounce: DB_CYCLES must be >= 2");
    end

    // Channels are independent: one lane instance per bit, no shared state.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        input_debounce_lane #(
            .DB_CYCLES (DB_CYCLES)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (raw[i]),
            .level_o (level[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

endmodule

// File: tb/tb_input_debounce.sv
module tb_input_debounce;

    localparam int W  = 4;
    localparam int DB = 4;

    typedef struct packed {
        logic [W-1:0] level;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] raw;
    logic [W-1:0] level, rise, fall;

    int checks   = 0;
    int failures = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;

    input_debounce #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The filter sees raw delayed by two edges (zeros right after reset).
    // A level flips at an edge when the last DB filter inputs (since reset)
    // all disagree with the current level.
    logic [W-1:0] rawq[$];
    logic [W-1:0] s2hist[$];
    logic [W-1:0] lvl_m;
    exp_t         expq[$];

    always @(posedge clk) begin
        exp_t         e;
        logic [W-1:0] s2;
        bit           alld;
        e = '0;
        if (!rst_n) begin
            rawq   = '{4'h0, 4'h0};
            s2hist.delete();
            lvl_m  = '0;
        end else begin
            s2 = rawq[rawq.size()-2];
            rawq.push_back(raw);
            if (rawq.size() > 3) void'(rawq.pop_front());
            s2hist.push_back(s2);
            if (s2hist.size() > DB) void'(s2hist.pop_front());
            for (int i = 0; i < W; i++) begin
                alld = (s2hist.size() == DB);
                foreach (s2hist[k]) if (s2hist[k][i] == lvl_m[i]) alld = 0;
                if (alld) begin
                    lvl_m[i] = ~lvl_m[i];
                    if (lvl_m[i]) e.rise[i] = 1'b1;
                    else          e.fall[i] = 1'b1;
                end
            end
            e.level = lvl_m;
        end
        expq.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        exp_t e;
        #1;
        checks++;
        if (expq.size() == 0) begin
            failures++;
            $display("FAIL sb_empty t=%0t no expected entry", $time);
        end else begin
            e = expq.pop_front();
            if ({level, rise, fall} !== e) begin
                failures++;
                $display("FAIL out t=%0t got lvl=%h rise=%h fall=%h exp lvl=%h rise=%h fall=%h",
                         $time, level, rise, fall, e.level, e.rise, e.fall);
            end
        end
        rise_cnt += $countones(rise);
        fall_cnt += $countones(fall);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int first;
        int hold[W];
        rst_n = 1'b0;
        raw   = 4'hF;
        cyc(10);

        // Release with all inputs high: rise=F expected on the 6th edge.
        rst_n = 1'b1;
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #2;
            if (first == 0 && rise == 4'hF) first = k;
        end
        checks++;
        if (first != 6) begin
            failures++;
            $display("FAIL rel_latency got edge=%0d exp edge=6", first);
        end

        @(negedge clk);
        raw = 4'h0;                      cyc(10);  // clean falls
        raw[0] = 1'b1;                   cyc(10);  // clean rise
        raw[1] = 1'b1; cyc(3);                     // bounce on channel 1
        raw[1] = 1'b0; cyc(1);
        raw[1] = 1'b1;                   cyc(10);
        raw[2] = 1'b1;                   cyc(10);
        raw[2] = 1'b0;                   cyc(10);  // clean fall ch2
        raw[3:2] = 2'b11;                cyc(10);  // simultaneous rise
        raw = 4'h0;                      cyc(10);
        raw[0] = 1'b1;                   cyc(3);   // reset mid-count
        rst_n = 1'b0;                    cyc(2);
        rst_n = 1'b1;                    cyc(10);
        // Excursions of exactly DB-1 and DB synchroniser edges.
        raw[1] = 1'b1; cyc(DB-1); raw[1] = 1'b0; cyc(10);
        raw[1] = 1'b1; cyc(DB);   raw[1] = 1'b0; cyc(12);

        // Random: per-channel hold times around the filter length.
        foreach (hold[i]) hold[i] = 0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < W; i++) begin
                if (hold[i] == 0) begin
                    raw[i]  = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 2*DB+2);
                end else begin
                    hold[i]--;
                end
            end
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                cyc($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            cyc(1);
        end
        cyc(3);

        checks++;
        if (rise_cnt == 0) begin
            failures++;
            $display("FAIL rise_seen got=%0d exp>0", rise_cnt);
        end
        checks++;
        if (fall_cnt == 0) begin
            failures++;
            $display("FAIL fall_seen got=%0d exp>0", fall_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
